// File: rtl/sprite_pos_ctrl.sv
// Sprite position controller: on each frame_start it fetches one accelerometer
// sample, derives a clamped target from the screen centre and slews toward it.
module sprite_pos_ctrl #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int SPRITE   = 13,
  parameter int MARGIN   = 8,
  parameter int MAX_STEP = 64,
  parameter int TIMEOUT  = 255
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       frame_start,
  input  logic       sample_ack,
  input  logic [9:0] smooth_outx,
  input  logic [9:0] smooth_outy,
  output logic       sample_req,
  output logic [9:0] sprite_col,
  output logic [9:0] sprite_row,
  output logic       pos_valid,
  output logic       busy,
  output logic       overrun,
  output logic       timeout_err,
  output logic [9:0] frame_count
);

  localparam int CX     = (H_ACTIVE - SPRITE + 1) / 2;
  localparam int CY     = (V_ACTIVE - SPRITE + 1) / 2;
  localparam int X_MAX  = H_ACTIVE - SPRITE - MARGIN;
  localparam int Y_MAX  = V_ACTIVE - SPRITE - MARGIN;
  localparam int WAIT_W = $clog2(TIMEOUT + 1);

  localparam logic signed [11:0] CX_S    = 12'(CX);
  localparam logic signed [11:0] CY_S    = 12'(CY);
  localparam logic signed [11:0] MIN_S   = 12'(MARGIN);
  localparam logic signed [11:0] X_MAX_S = 12'(X_MAX);
  localparam logic signed [11:0] Y_MAX_S = 12'(Y_MAX);
  localparam logic signed [11:0] STEP_S  = 12'(MAX_STEP);
  localparam logic [WAIT_W-1:0]  WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    CALC = 2'd2,
    STEP = 2'd3
  } state_t;

  state_t            state_r;
  state_t            state_s;
  logic              ack_take_s;
  logic              timeout_s;
  logic [WAIT_W-1:0] wait_cnt_r;
  logic [9:0]        sx_r;
  logic [9:0]        sy_r;
  logic signed [11:0] tx_r;
  logic signed [11:0] ty_r;
  logic              sample_req_r;
  logic [9:0]        sprite_col_r;
  logic [9:0]        sprite_row_r;
  logic              pos_valid_r;
  logic              busy_r;
  logic              overrun_r;
  logic              timeout_err_r;
  logic [9:0]        frame_count_r;

  function automatic logic signed [11:0] clamp12(
    input logic signed [11:0] v,
    input logic signed [11:0] lo,
    input logic signed [11:0] hi
  );
    if (v < lo) begin
      return lo;
    end else if (v > hi) begin
      return hi;
    end else begin
      return v;
    end
  endfunction

  // Slew limit: jump straight to target when within one step, else move one step.
  function automatic logic [9:0] step_axis(
    input logic [9:0]         cur,
    input logic signed [11:0] tgt
  );
    logic signed [11:0] diff;
    diff = tgt - $signed({2'b00, cur});
    if (diff > STEP_S) begin
      return cur + 10'(MAX_STEP);
    end else if (diff < -STEP_S) begin
      return cur - 10'(MAX_STEP);
    end else begin
      return tgt[9:0];
    end
  endfunction

  // FSM state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic plus the ack-capture and timeout strobes.
  always_comb begin
    state_s    = state_r;
    ack_take_s = 1'b0;
    timeout_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (frame_start) begin
          state_s = REQ;
        end else begin
          state_s = IDLE;
        end
      end
      REQ: begin
        if (sample_ack) begin
          state_s    = CALC;
          ack_take_s = 1'b1;
        end else if (wait_cnt_r == WAIT_LAST) begin
          state_s   = IDLE;
          timeout_s = 1'b1;
        end else begin
          state_s = REQ;
        end
      end
      CALC:    state_s = STEP;
      STEP:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Datapath and registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wait_cnt_r    <= '0;
      sx_r          <= 10'd0;
      sy_r          <= 10'd0;
      tx_r          <= CX_S;
      ty_r          <= CY_S;
      sample_req_r  <= 1'b0;
      sprite_col_r  <= 10'(CX);
      sprite_row_r  <= 10'(CY);
      pos_valid_r   <= 1'b0;
      busy_r        <= 1'b0;
      overrun_r     <= 1'b0;
      timeout_err_r <= 1'b0;
      frame_count_r <= 10'd0;
    end else begin
      sample_req_r <= (state_s == REQ);
      busy_r       <= (state_s != IDLE);
      overrun_r    <= frame_start && (state_r != IDLE);
      pos_valid_r  <= (state_r == STEP);

      if ((state_r == REQ) && !sample_ack) begin
        wait_cnt_r <= wait_cnt_r + WAIT_W'(1);
      end else begin
        wait_cnt_r <= '0;
      end

      if (ack_take_s) begin
        sx_r <= smooth_outx;
        sy_r <= smooth_outy;
      end

      // Offsets are sign-extended before adding so the clamp sees true negatives.
      if (state_r == CALC) begin
        tx_r <= clamp12(CX_S + $signed({{2{sx_r[9]}}, sx_r}), MIN_S, X_MAX_S);
        ty_r <= clamp12(CY_S + $signed({{2{sy_r[9]}}, sy_r}), MIN_S, Y_MAX_S);
      end

      if (state_r == STEP) begin
        sprite_col_r  <= step_axis(sprite_col_r, tx_r);
        sprite_row_r  <= step_axis(sprite_row_r, ty_r);
        frame_count_r <= frame_count_r + 10'd1;
        timeout_err_r <= 1'b0;
      end else if (timeout_s) begin
        timeout_err_r <= 1'b1;
      end
    end
  end

  assign sample_req  = sample_req_r;
  assign sprite_col  = sprite_col_r;
  assign sprite_row  = sprite_row_r;
  assign pos_valid   = pos_valid_r;
  assign busy        = busy_r;
  assign overrun     = overrun_r;
  assign timeout_err = timeout_err_r;
  assign frame_count = frame_count_r;

endmodule

// File: tb/tb_sprite_pos_ctrl.sv
// Self-checking bench for sprite_pos_ctrl: directed scenarios plus random frames
// compared against an integer model of the centre/clamp/slew rules.
module tb_sprite_pos_ctrl;

  logic       clock = 1'b0;
  logic       reset;
  logic       frame_start;
  logic       sample_ack;
  logic [9:0] smooth_outx;
  logic [9:0] smooth_outy;
  logic       sample_req;
  logic [9:0] sprite_col;
  logic [9:0] sprite_row;
  logic       pos_valid;
  logic       busy;
  logic       overrun;
  logic       timeout_err;
  logic [9:0] frame_count;

  sprite_pos_ctrl dut (
    .clock       (clock),
    .reset       (reset),
    .frame_start (frame_start),
    .sample_ack  (sample_ack),
    .smooth_outx (smooth_outx),
    .smooth_outy (smooth_outy),
    .sample_req  (sample_req),
    .sprite_col  (sprite_col),
    .sprite_row  (sprite_row),
    .pos_valid   (pos_valid),
    .busy        (busy),
    .overrun     (overrun),
    .timeout_err (timeout_err),
    .frame_count (frame_count)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int mcol, mrow, mcount, mterr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int clampi(input int v, input int lo, input int hi);
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

  function automatic int move_to(input int cur, input int tgt);
    if (tgt - cur > 64) return cur + 64;
    if (cur - tgt > 64) return cur - 64;
    return tgt;
  endfunction

  task automatic tick;
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic model_reset;
    mcol   = (640 - 13 + 1) / 2;
    mrow   = (480 - 13 + 1) / 2;
    mcount = 0;
    mterr  = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req"},   32'(sample_req),  32'd0);
    check({tag, "_busy"},  32'(busy),        32'd0);
    check({tag, "_pv"},    32'(pos_valid),   32'd0);
    check({tag, "_ovr"},   32'(overrun),     32'd0);
    check({tag, "_terr"},  32'(timeout_err), 32'd0);
    check({tag, "_col"},   32'(sprite_col),  32'd314);
    check({tag, "_row"},   32'(sprite_row),  32'd234);
    check({tag, "_count"}, 32'(frame_count), 32'd0);
  endtask

  task automatic pulse_reset;
    reset = 1'b1;
    #1;
    check_reset_outputs("rst");
    @(negedge clock);
    reset = 1'b0;
    model_reset();
  endtask

  // One full request/update; delay = idle cycles before ack (>=1 when fs_in_req).
  task automatic do_frame(input int sx, input int sy, input int delay,
                          input bit fs_in_req, input bit fs_at_step);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    check("req_rise", 32'(sample_req), 32'd1);
    check("busy_req", 32'(busy), 32'd1);
    for (int i = 0; i < delay; i++) begin
      if (fs_in_req && i == 0) frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      check("req_hold", 32'(sample_req), 32'd1);
      check("ovr_req", 32'(overrun), (fs_in_req && i == 0) ? 32'd1 : 32'd0);
    end
    smooth_outx = 10'(sx);
    smooth_outy = 10'(sy);
    sample_ack  = 1'b1;
    tick();
    sample_ack  = 1'b0;
    smooth_outx = 10'($urandom);
    smooth_outy = 10'($urandom);
    check("req_drop", 32'(sample_req), 32'd0);
    check("busy_e", 32'(busy), 32'd1);
    tick();
    check("pv_calc", 32'(pos_valid), 32'd0);
    check("col_calc", 32'(sprite_col), 32'(mcol));
    check("row_calc", 32'(sprite_row), 32'(mrow));
    check("terr_calc", 32'(timeout_err), 32'(mterr));
    if (fs_at_step) frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    mcol   = move_to(mcol, clampi(314 + sx, 8, 619));
    mrow   = move_to(mrow, clampi(234 + sy, 8, 459));
    mcount = (mcount + 1) % 1024;
    mterr  = 0;
    check("pv_step", 32'(pos_valid), 32'd1);
    check("col_step", 32'(sprite_col), 32'(mcol));
    check("row_step", 32'(sprite_row), 32'(mrow));
    check("count_step", 32'(frame_count), 32'(mcount));
    check("terr_step", 32'(timeout_err), 32'd0);
    check("busy_step", 32'(busy), 32'd0);
    check("ovr_step", 32'(overrun), fs_at_step ? 32'd1 : 32'd0);
    tick();
    check("pv_after", 32'(pos_valid), 32'd0);
    check("req_after", 32'(sample_req), 32'd0);
    check("busy_after", 32'(busy), 32'd0);
    check("ovr_after", 32'(overrun), 32'd0);
    check("col_after", 32'(sprite_col), 32'(mcol));
  endtask

  int exp_c18[3] = '{250, 186, 164};
  int exp_r18[3] = '{170, 134, 134};
  int exp_r19[5] = '{170, 106, 42, 8, 8};

  initial begin
    reset       = 1'b1;
    frame_start = 1'b0;
    sample_ack  = 1'b0;
    smooth_outx = 10'd0;
    smooth_outy = 10'd0;
    model_reset();
    @(negedge clock);
    check_reset_outputs("init");
    @(negedge clock);
    reset = 1'b0;
    tick();

    // Zero offset keeps the sprite centred.
    do_frame(0, 0, 3, 1'b0, 1'b0);
    check("z_col", 32'(sprite_col), 32'd314);
    check("z_row", 32'(sprite_row), 32'd234);
    check("z_count", 32'(frame_count), 32'd1);

    pulse_reset();
    for (int i = 0; i < 3; i++) begin
      do_frame(-150, -100, i, 1'b0, 1'b0);
      check("n150_col", 32'(sprite_col), 32'(exp_c18[i]));
      check("n150_row", 32'(sprite_row), 32'(exp_r18[i]));
    end

    pulse_reset();
    for (int i = 0; i < 5; i++) begin
      do_frame(0, -260, 2, 1'b0, 1'b0);
      check("n260_row", 32'(sprite_row), 32'(exp_r19[i]));
      check("n260_col", 32'(sprite_col), 32'd314);
    end

    pulse_reset();
    for (int i = 0; i < 8; i++) do_frame(511, 511, 1, 1'b0, 1'b0);
    check("sat_col", 32'(sprite_col), 32'd619);
    check("sat_row", 32'(sprite_row), 32'd459);

    // Timeout: request held for 255 cycles, then dropped with sticky error.
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    for (int i = 1; i < 255; i++) tick();
    check("to_hold", 32'(sample_req), 32'd1);
    tick();
    mterr = 1;
    check("to_req", 32'(sample_req), 32'd0);
    check("to_terr", 32'(timeout_err), 32'd1);
    check("to_busy", 32'(busy), 32'd0);
    check("to_col", 32'(sprite_col), 32'(mcol));
    check("to_row", 32'(sprite_row), 32'(mrow));
    check("to_count", 32'(frame_count), 32'(mcount));
    tick();
    check("to_sticky", 32'(timeout_err), 32'd1);
    do_frame(-40, 17, 2, 1'b0, 1'b0);

    // Overrun during REQ and on the final STEP edge.
    do_frame(100, -50, 3, 1'b1, 1'b0);
    do_frame(-300, 200, 2, 1'b0, 1'b1);

    // Ack while idle must be ignored.
    smooth_outx = 10'd200;
    smooth_outy = 10'd200;
    sample_ack  = 1'b1;
    tick();
    tick();
    sample_ack = 1'b0;
    check("ack_idle_req", 32'(sample_req), 32'd0);
    check("ack_idle_busy", 32'(busy), 32'd0);
    check("ack_idle_col", 32'(sprite_col), 32'(mcol));
    check("ack_idle_count", 32'(frame_count), 32'(mcount));

    for (int i = 0; i < 30; i++) begin
      do_frame(int'($urandom_range(0, 1023)) - 512, int'($urandom_range(0, 1023)) - 512,
               int'($urandom_range(1, 8)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    // Reset while a request is outstanding.
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    check("mid_req", 32'(sample_req), 32'd1);
    reset = 1'b1;
    #1;
    check_reset_outputs("mid_rst");
    @(negedge clock);
    reset = 1'b0;
    model_reset();
    sample_ack = 1'b1;
    tick();
    tick();
    sample_ack = 1'b0;
    tick();
    check("post_rst_req", 32'(sample_req), 32'd0);
    check("post_rst_pv", 32'(pos_valid), 32'd0);
    check("post_rst_count", 32'(frame_count), 32'd0);
    do_frame(33, -77, 1, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sprite_pos_ctrl.md
SPRITE_POS_CTRL -- requirements
Module: sprite_pos_ctrl

Interface
REQ-001: Parameters SHALL be, one per line as name, default, meaning:
  H_ACTIVE, 640, visible columns
  V_ACTIVE, 480, visible rows
  SPRITE, 13, sprite width and height in pixels
  MARGIN, 8, minimum distance from sprite edge to screen edge
  MAX_STEP, 64, maximum position change per axis per update
  TIMEOUT, 255, maximum cycles to wait for sample_ack
REQ-002: Clock and reset SHALL be "one clock; reset is asynchronous and active-high", with ports named clock and reset.
REQ-003: Ports SHALL be, as name, direction, width, meaning:
  clock  in  1  system clock
  reset  in  1  asynchronous active-high reset
  frame_start  in  1  one-cycle pulse at start of vertical blanking
  sample_ack  in  1  accelerometer reader has valid data on smooth_outx/y
  smooth_outx  in  10  signed two's-complement X offset
  smooth_outy  in  10  signed two's-complement Y offset
  sample_req  out  1  request for a new accelerometer sample
  sprite_col  out  10  sprite top-left column
  sprite_row  out  10  sprite top-left row
  pos_valid  out  1  one-cycle pulse when sprite_col/row update
  busy  out  1  high whenever the FSM is not in IDLE
  overrun  out  1  one-cycle pulse when frame_start arrives while busy
  timeout_err  out  1  sticky flag for the last request timing out
  frame_count  out  10  count of completed updates

Function
REQ-004: FSM states SHALL be IDLE, REQ, CALC and STEP.
REQ-005: In IDLE, frame_start=1 SHALL move the FSM to REQ at the next edge and raise sample_req at that edge.
REQ-006: In REQ, sample_req SHALL stay high until sample_ack=1 is sampled. On that edge (E), smooth_outx/y SHALL be captured, sample_req SHALL drop, and the FSM SHALL move to CALC.
REQ-007: In REQ, a wait counter SHALL count the cycles spent waiting. When it reaches TIMEOUT without sample_ack:
  - sample_req SHALL drop;
  - timeout_err SHALL be set to 1;
  - the position and frame_count SHALL stay unchanged;
  - the FSM SHALL return to IDLE.
REQ-008: At edge E+1 (CALC), the target SHALL be computed in at least 12-bit signed arithmetic:
  - tx = 314 + sx and ty = 234 + sy, where the centre values are (H_ACTIVE-SPRITE+1)/2 and (V_ACTIVE-SPRITE+1)/2;
  - tx SHALL be clamped to [MARGIN, H_ACTIVE-SPRITE-MARGIN] = [8, 619];
  - ty SHALL be clamped to [MARGIN, V_ACTIVE-SPRITE-MARGIN] = [8, 459].
REQ-009: At edge E+2 (STEP), each axis SHALL move toward its target as follows:
  - if |target-current| <= MAX_STEP, current = target;
  - otherwise, current moves by exactly MAX_STEP in the direction of the target.
REQ-010: Also at E+2:
  - pos_valid SHALL pulse for one cycle;
  - frame_count SHALL increment, wrapping from 1023 to 0;
  - timeout_err SHALL clear;
  - the FSM SHALL return to IDLE.
REQ-011: frame_start in any state other than IDLE SHALL be ignored for sequencing and SHALL produce a one-cycle overrun pulse.
REQ-012: sample_ack outside REQ SHALL be ignored.
REQ-013: If frame_start and the final STEP edge fall on the same cycle, frame_start SHALL count as an overrun and SHALL NOT start a new request.
REQ-014: sprite_col and sprite_row SHALL change only at the STEP edge and SHALL stay stable at all other times.

Reset
REQ-015: reset=1 SHALL asynchronously force:
  - state = IDLE;
  - sample_req, busy, pos_valid, overrun, timeout_err = 0;
  - sprite_col = 314 and sprite_row = 234;
  - frame_count = 0;
  - the wait counter = 0.
REQ-016: Reset asserted mid-request SHALL drop sample_req immediately. After reset releases, no update SHALL occur until a new frame_start arrives.

Verification
REQ-017: sx=0, sy=0, ack 3 cycles after req -> sprite_col=314 and sprite_row=234 at E+2, pos_valid pulse, frame_count=1.
REQ-018: sx=-150 (10'b1101101010), sy=-100, three frames -> col 250, 186, 164 and row 170, 134, 134.
REQ-019: sx=0, sy=-260 (10'b1011111100), five frames -> row 170, 106, 42, 8, 8 (clamped), col held at 314.
REQ-020: sx=+511, sy=+511 from centre, repeated frames -> col saturates at 619 and row saturates at 459.
REQ-021: No ack -> sample_req drops after 255 waiting cycles, timeout_err=1, position and frame_count unchanged; the next successful update clears timeout_err.
REQ-022: frame_start while in REQ -> overrun pulse for one cycle, no second request. Reset asserted while in REQ -> sample_req=0 immediately and all outputs at their reset values.
